line_buffer_ctrl: RTL and testbench
===================================

Name: line_buffer_ctrl

Overview:
- Sequences the 3-row line buffer for one conv layer pass over a multi-channel feature map.
- Accepts a pixel stream with a valid/ready handshake, drives the buffer's pixel_valid, clear, x and y inputs, and flags when a full 3x3 window is available downstream.
- Steps through channels, pulsing clear before each one, and reports per-channel and per-layer completion.

Parameters:
- MAX_WIDTH, 128, largest supported image width; must match the line buffer depth.
- MAX_HEIGHT, 1023, largest supported image height.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; latches the configuration and begins a layer
- abort  input  1  synchronous cancel back to IDLE
- img_width  input  8  width in pixels; legal range 3..MAX_WIDTH
- img_height  input  10  height in rows; legal range 3..MAX_HEIGHT
- num_channels  input  8  channel count; legal range 1..255
- in_valid  input  1  upstream pixel valid
- in_ready  output  1  controller can accept a pixel
- win_ready  input  1  downstream conv engine can accept a window
- lb_pixel_valid  output  1  drives the line buffer's pixel_valid
- lb_clear  output  1  drives the line buffer's clear
- lb_x  output  11  column of the current accepted pixel
- lb_y  output  10  row of the current accepted pixel
- window_valid  output  1  a 3x3 window is present at the line buffer outputs
- win_cx  output  11  window centre column (x-1 of the completing pixel)
- win_cy  output  10  window centre row (y-1 of the completing pixel)
- channel  output  8  current channel index
- busy  output  1  high in every state except IDLE
- channel_done  output  1  one-cycle pulse at the end of each channel
- done  output  1  one-cycle pulse at the end of the layer
- cfg_error  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: all registered outputs are 0, the FSM is in IDLE, and the latched config and counters are 0.
- States:
  - IDLE:
    - On start, check the config. If width<3, width>MAX_WIDTH, height<3, height>MAX_HEIGHT or channels==0, pulse cfg_error and stay in IDLE.
    - Otherwise latch width, height and channels, set channel=0, and go to CLEAR.
  - CLEAR:
    - lb_clear=1 for exactly one cycle; the x and y counters are set to 0.
    - Next state is STREAM.
  - STREAM:
    - in_ready = win_ready (combinational, this state only).
    - lb_pixel_valid = in_valid & in_ready (combinational).
    - lb_x and lb_y show the counters for the pixel being accepted.
    - On acceptance: x increments. When x==width-1, x wraps to 0 and y increments.
    - Acceptance of the pixel at x=width-1, y=height-1 moves the FSM to FLUSH.
  - FLUSH:
    - One cycle, which lets the final window_valid emerge.
    - Pulse channel_done.
    - If channel==num_channels-1, go to DONE. Otherwise increment channel and go to CLEAR.
  - DONE: pulse done for one cycle and return to IDLE; channel keeps its final value until the next start.
- Window detection:
  - window_valid is registered one cycle after an acceptance, matching the line buffer's one-cycle output latency.
  - It is asserted when the accepted pixel had x>=2 and y>=2.
  - win_cx and win_cy are registered alongside window_valid.
  - There are (W-2)*(H-2) windows per channel; none straddle a row wrap.
- Stall: when win_ready=0, in_ready=0, no pixel is accepted and all counters hold.
- start while busy=1 is ignored.
- abort takes priority over all other inputs in every state:
  - next cycle the FSM is in IDLE with busy=0;
  - no channel_done or done is issued;
  - window_valid is forced to 0.
- reset mid-operation returns everything to the reset values immediately.
- No pixel is accepted in CLEAR, FLUSH, DONE or IDLE (in_ready=0 in all of them).
- The channel counter is 8 bits and never wraps, because channels<=255 and the final channel exits to DONE.

Test Plan:
- Config W=4, H=3, C=1, in_valid held high, win_ready=1:
  - lb_clear pulses once, then 12 accepts occur;
  - window_valid pulses at (cx,cy)=(1,1) and (2,1);
  - channel_done and done are each seen once, and busy returns to 0.
- Config W=5, H=5, C=3:
  - exactly 3 lb_clear pulses and 3 channel_done pulses;
  - 9 windows per channel, 27 in total;
  - channel reads 0, 1, 2 in turn.
- Same run as the W=5, H=5 case with win_ready toggling every 3 cycles and in_valid random:
  - no acceptance while win_ready=0;
  - counters never skip or duplicate;
  - the window count is still 27.
- start with W=2, then H=1024, then C=0: a cfg_error pulse each time, busy stays 0, and lb_clear never asserts.
- abort in the middle of channel 1 of a C=3 run: busy=0 next cycle and no done pulse. A following start with W=4, H=3, C=1 completes normally.
- Assert reset during STREAM: all outputs are 0 while reset is high, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// Sequencer for a 3-row line buffer over a multi-channel feature map.
// Counts pixel coordinates, flags complete 3x3 windows, steps channels.
module line_buffer_ctrl #(
  parameter int MAX_WIDTH  = 128,
  parameter int MAX_HEIGHT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  img_width,
  input  logic [9:0]  img_height,
  input  logic [7:0]  num_channels,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        win_ready,
  output logic        lb_pixel_valid,
  output logic        lb_clear,
  output logic [10:0] lb_x,
  output logic [9:0]  lb_y,
  output logic        window_valid,
  output logic [10:0] win_cx,
  output logic [9:0]  win_cy,
  output logic [7:0]  channel,
  output logic        busy,
  output logic        channel_done,
  output logic        done,
  output logic        cfg_error
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, STREAM, FLUSH, DONE
  } state_t;

  localparam logic [8:0]  MAXW = 9'(MAX_WIDTH);
  localparam logic [10:0] MAXH = 11'(MAX_HEIGHT);

  state_t      state, state_nx;
  logic [7:0]  width_q;
  logic [9:0]  height_q;
  logic [7:0]  chans_q;
  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic        cfg_ok;
  logic        accept;
  logic        x_last;
  logic        y_last;
  logic        ch_last;

  assign cfg_ok = (img_width >= 8'd3)
               && ({1'b0, img_width} <= MAXW)
               && (img_height >= 10'd3)
               && ({1'b0, img_height} <= MAXH)
               && (num_channels != 8'd0);

  assign x_last  = (x_q == {3'b000, width_q} - 11'd1);
  assign y_last  = (y_q == height_q - 10'd1);
  assign ch_last = (channel == chans_q - 8'd1);
  assign accept  = lb_pixel_valid;
  assign lb_x    = x_q;
  assign lb_y    = y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:   if (start && cfg_ok) state_nx = CLEAR;
        CLEAR:  state_nx = STREAM;
        STREAM: if (accept && x_last && y_last) state_nx = FLUSH;
        FLUSH:  state_nx = ch_last ? DONE : CLEAR;
        DONE:   state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Abort suppresses every strobe in the cycle it is seen.
  always_comb begin
    in_ready     = 1'b0;
    lb_clear     = 1'b0;
    channel_done = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    unique case (state)
      CLEAR:  lb_clear     = ~abort;
      STREAM: in_ready     = win_ready & ~abort;
      FLUSH:  channel_done = ~abort;
      DONE:   done         = ~abort;
      default: ;
    endcase
    lb_pixel_valid = in_valid & in_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q      <= '0;
      height_q     <= '0;
      chans_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      channel      <= '0;
      window_valid <= 1'b0;
      win_cx       <= '0;
      win_cy       <= '0;
      cfg_error    <= 1'b0;
    end else begin
      cfg_error    <= 1'b0;
      window_valid <= 1'b0;
      if (!abort) begin
        unique case (state)
          IDLE: begin
            if (start && cfg_ok) begin
              width_q  <= img_width;
              height_q <= img_height;
              chans_q  <= num_channels;
              channel  <= '0;
            end else if (start) begin
              cfg_error <= 1'b1;
            end
          end
          CLEAR: begin
            x_q <= '0;
            y_q <= '0;
          end
          STREAM: begin
            if (accept) begin
              // Line buffer output lags one cycle; centre is one back.
              window_valid <= (x_q >= 11'd2) && (y_q >= 10'd2);
              win_cx       <= x_q - 11'd1;
              win_cy       <= y_q - 10'd1;
              if (x_last) begin
                x_q <= '0;
                y_q <= y_q + 10'd1;
              end else begin
                x_q <= x_q + 11'd1;
              end
            end
          end
          FLUSH: begin
            if (!ch_last) channel <= channel + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a pixel/window scoreboard.
// Expected coordinates are queued up front and popped as the DUT emits.
module tb_line_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  img_width = '0;
  logic [9:0]  img_height = '0;
  logic [7:0]  num_channels = '0;
  logic        in_valid = 1'b0;
  logic        win_ready = 1'b0;
  logic        in_ready;
  logic        lb_pixel_valid;
  logic        lb_clear;
  logic [10:0] lb_x;
  logic [9:0]  lb_y;
  logic        window_valid;
  logic [10:0] win_cx;
  logic [9:0]  win_cy;
  logic [7:0]  channel;
  logic        busy;
  logic        channel_done;
  logic        done;
  logic        cfg_error;

  line_buffer_ctrl dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .img_width(img_width),
    .img_height(img_height),
    .num_channels(num_channels),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .win_ready(win_ready),
    .lb_pixel_valid(lb_pixel_valid),
    .lb_clear(lb_clear),
    .lb_x(lb_x),
    .lb_y(lb_y),
    .window_valid(window_valid),
    .win_cx(win_cx),
    .win_cy(win_cy),
    .channel(channel),
    .busy(busy),
    .channel_done(channel_done),
    .done(done),
    .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_clear = 0;
  int n_chd = 0;
  int n_done = 0;
  int n_acc = 0;
  int n_win = 0;
  logic [20:0] pixq[$];
  logic [28:0] winq[$];

  function automatic logic [63:0] outs();
    return 64'({in_ready, lb_pixel_valid, lb_clear, lb_x, lb_y,
                window_valid, win_cx, win_cy, channel, busy,
                channel_done, done, cfg_error});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [20:0] pe;
    logic [28:0] we;
    @(negedge clk);
    if (lb_clear) begin
      chk("clr_channel", 64'(channel), 64'(n_clear));
      n_clear++;
    end
    if (lb_pixel_valid) begin
      chk("stall", 64'(win_ready), 64'd1);
      if (pixq.size() > 0) pe = pixq.pop_front();
      else pe = '1;
      chk("pixel", 64'({lb_x, lb_y}), 64'(pe));
      n_acc++;
    end
    if (window_valid) begin
      if (winq.size() > 0) we = winq.pop_front();
      else we = '1;
      chk("window", 64'({win_cx, win_cy, channel}), 64'(we));
      n_win++;
    end
    if (channel_done) n_chd++;
    if (done) n_done++;
    @(posedge clk);
    #1;
  endtask

  task automatic prep(input int w, input int h, input int c);
    pixq.delete();
    winq.delete();
    n_clear = 0;
    n_chd = 0;
    n_done = 0;
    n_acc = 0;
    n_win = 0;
    for (int ch = 0; ch < c; ch++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          pixq.push_back({11'(x), 10'(y)});
          if (x >= 2 && y >= 2)
            winq.push_back({11'(x - 1), 10'(y - 1), 8'(ch)});
        end
  endtask

  task automatic go(input int w, input int h, input int c);
    img_width = w[7:0];
    img_height = h[9:0];
    num_channels = c[7:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stim(input int mode, input int k);
    if (mode == 0) begin
      in_valid = 1'b1;
      win_ready = 1'b1;
    end else begin
      win_ready = ((k / 3) % 2) == 0;
      in_valid = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_layer(input int w, input int h, input int c,
                           input int mode);
    prep(w, h, c);
    go(w, h, c);
    for (int k = 0; k < 5000 && n_done == 0; k++) begin
      stim(mode, k);
      tick();
    end
    in_valid = 1'b0;
    win_ready = 1'b0;
    chk("done_cnt", 64'(n_done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("clears", 64'(n_clear), 64'(c));
    chk("ch_done", 64'(n_chd), 64'(c));
    chk("accepts", 64'(n_acc), 64'(w * h * c));
    chk("windows", 64'(n_win), 64'((w - 2) * (h - 2) * c));
    chk("pix_left", 64'(pixq.size()), 64'd0);
    chk("win_left", 64'(winq.size()), 64'd0);
    chk("channel_end", 64'(channel), 64'(c - 1));
  endtask

  int cw[4] = '{2, 5, 5, 129};
  int chh[4] = '{5, 1024, 5, 5};
  int cc[4] = '{1, 1, 0, 1};

  initial begin
    tick();
    chk("reset_outs", outs(), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_outs", outs(), 64'd0);

    run_layer(4, 3, 1, 0);
    run_layer(5, 5, 3, 0);
    run_layer(5, 5, 3, 1);

    n_clear = 0;
    for (int i = 0; i < 4; i++) begin
      go(cw[i], chh[i], cc[i]);
      chk("cfg_err", 64'(cfg_error), 64'd1);
      chk("cfg_busy", 64'(busy), 64'd0);
      tick();
      chk("cfg_err_pulse", 64'(cfg_error), 64'd0);
    end
    chk("cfg_noclear", 64'(n_clear), 64'd0);

    prep(5, 5, 3);
    go(5, 5, 3);
    for (int k = 0; k < 2000 && n_clear < 2; k++) begin
      stim(0, k);
      tick();
    end
    for (int k = 0; k < 6; k++) tick();
    chk("abort_ch", 64'(channel), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    win_ready = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_win", 64'(window_valid), 64'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("abort_nodone", 64'(n_done), 64'd0);
    chk("abort_chd", 64'(n_chd), 64'd1);
    run_layer(4, 3, 1, 0);

    prep(5, 5, 1);
    go(5, 5, 1);
    for (int k = 0; k < 10; k++) begin
      stim(0, k);
      tick();
    end
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_outs", outs(), 64'd0);
    tick();
    chk("rst_hold_outs", outs(), 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_idle_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    win_ready = 1'b0;
    run_layer(4, 3, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
